// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types, defaults and operand slicing helper for pipe_stage_reg
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  localparam int DEFAULT_NOP_OP = 0;

  // Bit offset of operand word k inside a packed operand bus.
  function automatic int op_lsb(input int k, input int data_w);
    return k * data_w;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating up-counter, cleared only by reset
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage register with 2-entry skid, flush and NOP masking
// Optional stall/bubble statistics counters under PIPE_STAGE_STATS_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              OP_W   = 5,
  parameter int              DATA_W = 32,
  parameter int              N_OPS  = 4,
  parameter logic [OP_W-1:0] NOP_OP = OP_W'(DEFAULT_NOP_OP),
  parameter int              CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         in_opcode,
  input  logic [N_OPS*DATA_W-1:0] in_ops,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OP_W-1:0]         out_opcode,
`ifdef PIPE_STAGE_STATS_EN
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        bubble_cnt,
`endif
  output logic [N_OPS*DATA_W-1:0] out_ops
);

  skid_state_e               state_q, state_d;
  logic [OP_W-1:0]           main_opcode_q, main_opcode_d;
  logic [N_OPS*DATA_W-1:0]   main_ops_q, main_ops_d;
  logic [OP_W-1:0]           skid_opcode_q, skid_opcode_d;
  logic [N_OPS*DATA_W-1:0]   skid_ops_q, skid_ops_d;

  logic accept;
  logic consume;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_d       = state_q;
    main_opcode_d = main_opcode_q;
    main_ops_d    = main_ops_q;
    skid_opcode_d = skid_opcode_q;
    skid_ops_d    = skid_ops_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d       = ONE;
          main_opcode_d = in_opcode;
          main_ops_d    = in_ops;
        end
      end
      ONE: begin
        if (accept && consume) begin
          main_opcode_d = in_opcode;
          main_ops_d    = in_ops;
        end else if (accept) begin
          state_d       = TWO;
          skid_opcode_d = in_opcode;
          skid_ops_d    = in_ops;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (consume) begin
          state_d       = ONE;
          main_opcode_d = skid_opcode_q;
          main_ops_d    = skid_ops_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush only drops the valid state; data flops may keep stale contents.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= EMPTY;
      main_opcode_q <= NOP_OP;
      main_ops_q    <= '0;
      skid_opcode_q <= NOP_OP;
      skid_ops_q    <= '0;
    end else begin
      state_q       <= state_d;
      main_opcode_q <= main_opcode_d;
      main_ops_q    <= main_ops_d;
      skid_opcode_q <= skid_opcode_d;
      skid_ops_q    <= skid_ops_d;
    end
  end

  assign out_opcode = out_valid ? main_opcode_q : NOP_OP;
  assign out_ops    = main_ops_q;

`ifdef PIPE_STAGE_STATS_EN
  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~out_valid),
    .count (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized and directed bench for pipe_stage_reg against a queue model
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int OP_W   = 5;
  localparam int DATA_W = 32;
  localparam int N_OPS  = 4;
  localparam int CNT_W  = 4;
  localparam int OPS_W  = N_OPS * DATA_W;
  localparam int SAT    = (1 << CNT_W) - 1;
  localparam logic [OP_W-1:0] NOP = '0;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [OP_W-1:0]  in_opcode = '0;
  logic [OPS_W-1:0] in_ops = '0;
  logic             in_ready;
  logic             out_valid;
  logic [OP_W-1:0]  out_opcode;
  logic [OPS_W-1:0] out_ops;
`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
`endif

  pipe_stage_reg #(
    .OP_W   (OP_W),
    .DATA_W (DATA_W),
    .N_OPS  (N_OPS),
    .NOP_OP (NOP),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_ops     (in_ops),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
`ifdef PIPE_STAGE_STATS_EN
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
`endif
    .out_ops    (out_ops)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [OPS_W-1:0] ops;
  } entry_t;

  entry_t mq[$];
  int     m_stall = 0;
  int     m_bubble = 0;

  task automatic chk(input string name, input logic [OPS_W-1:0] act, input logic [OPS_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [OPS_W-1:0] mk(input int a, input int b, input int c, input int d);
    logic [OPS_W-1:0] r;
    r = '0;
    r[op_lsb(0, DATA_W) +: DATA_W] = DATA_W'(a);
    r[op_lsb(1, DATA_W) +: DATA_W] = DATA_W'(b);
    r[op_lsb(2, DATA_W) +: DATA_W] = DATA_W'(c);
    r[op_lsb(3, DATA_W) +: DATA_W] = DATA_W'(d);
    return r;
  endfunction

  // Reference: a FIFO of at most two entries; flush empties it and drops the input.
  always @(posedge clk or posedge rst) begin : model
    bit has;
    bit room;
    if (rst) begin
      mq.delete();
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      has  = (mq.size() > 0);
      room = (mq.size() < 2);
      if (has && !out_ready) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
      if (!has) m_bubble = (m_bubble < SAT) ? m_bubble + 1 : SAT;
      if (flush) begin
        mq.delete();
      end else begin
        if (has && out_ready) void'(mq.pop_front());
        if (in_valid && room) mq.push_back('{op: in_opcode, ops: in_ops});
      end
    end
  end

  always @(negedge clk) begin : compare
    chk("out_valid", OPS_W'(out_valid), OPS_W'(mq.size() > 0));
    chk("in_ready", OPS_W'(in_ready), OPS_W'(mq.size() < 2));
    chk("out_opcode", OPS_W'(out_opcode), OPS_W'((mq.size() > 0) ? mq[0].op : NOP));
    if (mq.size() > 0) chk("out_ops", out_ops, mq[0].ops);
`ifdef PIPE_STAGE_STATS_EN
    chk("stall_cnt", OPS_W'(stall_cnt), OPS_W'(m_stall));
    chk("bubble_cnt", OPS_W'(bubble_cnt), OPS_W'(m_bubble));
`endif
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset held with a valid input present
    in_valid  = 1'b1;
    in_opcode = 5'h03;
    in_ops    = mk(1, 2, 3, 4);
    repeat (3) step();
    chk("rst_out_valid", OPS_W'(out_valid), OPS_W'(0));
    chk("rst_out_opcode", OPS_W'(out_opcode), OPS_W'(NOP));
    chk("rst_in_ready", OPS_W'(in_ready), OPS_W'(1));
    chk("rst_out_ops", out_ops, '0);
    rst = 1'b0;
    step();
    chk("first_valid", OPS_W'(out_valid), OPS_W'(1));
    chk("first_opcode", OPS_W'(out_opcode), OPS_W'(5'h03));
    chk("first_ops", out_ops, {32'd4, 32'd3, 32'd2, 32'd1});
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();

    // Streaming at full rate
    in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_opcode = OP_W'(i);
      in_ops    = mk(i, i * 10, i * 100, i * 1000);
      step();
      chk("stream_opcode", OPS_W'(out_opcode), OPS_W'(i));
      chk("stream_in_ready", OPS_W'(in_ready), OPS_W'(1));
    end
    in_valid = 1'b0;
    step();

    // Backpressure: one extra entry accepted, then order preserved
    in_valid  = 1'b1;
    in_opcode = 5'd20;
    step();
    out_ready = 1'b0;
    in_opcode = 5'd21;
    step();
    chk("bp_in_ready", OPS_W'(in_ready), OPS_W'(0));
    chk("bp_hold20", OPS_W'(out_opcode), OPS_W'(20));
    in_opcode = 5'd22;
    step();
    chk("bp_still20", OPS_W'(out_opcode), OPS_W'(20));
    out_ready = 1'b1;
    step();
    chk("bp_out21", OPS_W'(out_opcode), OPS_W'(21));
    chk("bp_ready_back", OPS_W'(in_ready), OPS_W'(1));
    step();
    chk("bp_out22", OPS_W'(out_opcode), OPS_W'(22));
    in_valid = 1'b0;
    step();
    chk("bp_drained", OPS_W'(out_valid), OPS_W'(0));

    // Flush with both entries full and a valid input
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_opcode = 5'd30;
    step();
    in_opcode = 5'd31;
    step();
    in_opcode = 5'd32;
    flush     = 1'b1;
    step();
    chk("flush_valid", OPS_W'(out_valid), OPS_W'(0));
    chk("flush_opcode", OPS_W'(out_opcode), OPS_W'(NOP));
    chk("flush_in_ready", OPS_W'(in_ready), OPS_W'(1));
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("flush_no_ghost", OPS_W'(out_valid), OPS_W'(0));

    // Flush and accept in the same cycle from EMPTY
    in_valid  = 1'b1;
    in_opcode = 5'd33;
    flush     = 1'b1;
    step();
    chk("flush_accept", OPS_W'(out_valid), OPS_W'(0));
    flush    = 1'b0;
    in_valid = 1'b0;

`ifdef PIPE_STAGE_STATS_EN
    repeat (16) step();
    chk("bubble_sat", OPS_W'(bubble_cnt), OPS_W'(SAT));
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_opcode = 5'd40;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    chk("stall_sat", OPS_W'(stall_cnt), OPS_W'(SAT));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("bubble_kept", OPS_W'(bubble_cnt), OPS_W'(SAT));
    chk("stall_kept", OPS_W'(stall_cnt), OPS_W'(SAT));
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_opcode = OP_W'($urandom);
      in_ops    = mk(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
      step();
    end

    // Mid-operation reset
    in_valid = 1'b1;
    flush    = 1'b0;
    out_ready = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", OPS_W'(out_valid), OPS_W'(0));
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
